// File: rtl/rc5_key_expand.sv
// RC5-16/16/16 key schedule: expands a 128-bit key into the 34-word subkey table, one mix step per clock.
// Define RC5_KEYGEN_FAST_INIT_EN to preload the whole P/Q table in LOAD and skip the serial INIT phase.
module rc5_key_expand #(
  parameter int W        = 16,
  parameter int ROUNDS   = 16,
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key,
  output logic                busy,
  output logic                ready,
  output logic                done,
  output logic [W-1:0]        sub [0:2*(ROUNDS+1)-1]
);

  localparam int T     = 2 * (ROUNDS + 1);
  localparam int C     = KEY_BITS / W;
  localparam int NMIX  = 3 * ((T > C) ? T : C);
  localparam int TW    = $clog2(T);
  localparam int CW    = $clog2(C);
  localparam int RW    = $clog2(W);
  localparam int CNT_W = $clog2(NMIX);

  localparam logic [W-1:0] P_INIT = W'(16'hB7E1);
  localparam logic [W-1:0] Q_STEP = W'(16'h9E37);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    INIT,
    MIX
  } state_t;

  state_t state, next_state;

  logic [W-1:0]     s_reg [0:T-1];
  logic [W-1:0]     l_reg [0:C-1];
  logic [W-1:0]     a_reg, b_reg;
  logic [TW-1:0]    i_idx;
  logic [CW-1:0]    j_idx;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0]    k_idx;

  logic accept, load_en, init_en, mix_en, last_mix;

  logic [W-1:0]   a_sum, a_new, ab_sum, l_sum, b_new;
  logic [2*W-1:0] b_dbl;

  assign k_idx = cnt[TW-1:0];
  assign busy  = (state != IDLE);
  assign sub   = s_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    load_en    = 1'b0;
    init_en    = 1'b0;
    mix_en     = 1'b0;
    last_mix   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        load_en = 1'b1;
`ifdef RC5_KEYGEN_FAST_INIT_EN
        next_state = MIX;
`else
        next_state = INIT;
`endif
      end
      INIT: begin
        init_en = 1'b1;
        if (cnt == CNT_W'(T - 2)) begin
          next_state = MIX;
        end
      end
      MIX: begin
        mix_en = 1'b1;
        if (cnt == CNT_W'(NMIX - 1)) begin
          last_mix   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Single mix datapath: A is a fixed rotate by 3, B a data-dependent rotate taken from {x,x}.
  always_comb begin
    a_sum  = s_reg[i_idx] + a_reg + b_reg;
    a_new  = {a_sum[W-4:0], a_sum[W-1:W-3]};
    ab_sum = a_new + b_reg;
    l_sum  = l_reg[j_idx] + ab_sum;
    b_dbl  = {l_sum, l_sum} << ab_sum[RW-1:0];
    b_new  = b_dbl[2*W-1:W];
  end

  // The key is captured on the accepting edge so it only has to be valid alongside start.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < T; n++) s_reg[n] <= '0;
      for (int n = 0; n < C; n++) l_reg[n] <= '0;
      a_reg <= '0;
      b_reg <= '0;
      i_idx <= '0;
      j_idx <= '0;
      cnt   <= '0;
      ready <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= last_mix;
      if (last_mix) begin
        ready <= 1'b1;
      end else if (accept) begin
        ready <= 1'b0;
      end

      if (accept) begin
        for (int n = 0; n < C; n++) l_reg[n] <= key[n*W +: W];
      end

      if (load_en) begin
`ifdef RC5_KEYGEN_FAST_INIT_EN
        for (int n = 0; n < T; n++) s_reg[n] <= W'(P_INIT + n * Q_STEP);
`else
        s_reg[0] <= P_INIT;
`endif
        a_reg <= '0;
        b_reg <= '0;
        i_idx <= '0;
        j_idx <= '0;
        cnt   <= '0;
      end

      if (init_en) begin
        s_reg[k_idx + 1'b1] <= s_reg[k_idx] + Q_STEP;
        cnt <= (cnt == CNT_W'(T - 2)) ? '0 : cnt + 1'b1;
      end

      if (mix_en) begin
        s_reg[i_idx] <= a_new;
        l_reg[j_idx] <= b_new;
        a_reg        <= a_new;
        b_reg        <= b_new;
        i_idx        <= (i_idx == TW'(T - 1)) ? '0 : i_idx + 1'b1;
        j_idx        <= (j_idx == CW'(C - 1)) ? '0 : j_idx + 1'b1;
        cnt          <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Self-checking bench for rc5_key_expand: table-driven keys against a behavioural RC5 key schedule,
// plus hand-written sequences for ignored start, mid-MIX reset and continuous re-triggering.
module tb_rc5_key_expand;

  localparam int T = 34;
`ifdef RC5_KEYGEN_FAST_INIT_EN
  localparam int INIT_CYC = 0;
`else
  localparam int INIT_CYC = 33;
`endif
  localparam int LAT = 1 + INIT_CYC + 102;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy, ready, done;
  logic [15:0]  sub [0:T-1];

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [127:0] key;
    logic [543:0] exp;
  } vec_t;

  vec_t vecs [4];

  rc5_key_expand dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .busy  (busy),
    .ready (ready),
    .done  (done),
    .sub   (sub)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int r);
    int rr;
    rr = r % 16;
    if (rr == 0) return x;
    return (x << rr) | (x >> (16 - rr));
  endfunction

  // Reference RC5 key schedule written straight from the algorithm description.
  task automatic model_table(input logic [127:0] k, output logic [543:0] e);
    logic [15:0] s [T];
    logic [15:0] l [8];
    logic [15:0] a, b, t;
    int i, j;
    for (int n = 0; n < 8; n++) l[n] = k[16*n +: 16];
    s[0] = 16'hB7E1;
    for (int n = 1; n < T; n++) s[n] = s[n-1] + 16'h9E37;
    a = 0; b = 0; i = 0; j = 0;
    for (int it = 0; it < 102; it++) begin
      t    = s[i] + a + b;
      a    = rotl16(t, 3);
      t    = a + b;
      b    = rotl16(l[j] + t, int'(t[3:0]));
      s[i] = a;
      l[j] = b;
      i    = (i + 1) % T;
      j    = (j + 1) % 8;
    end
    for (int n = 0; n < T; n++) e[16*n +: 16] = s[n];
  endtask

  function automatic logic [543:0] pack_sub();
    logic [543:0] p;
    for (int n = 0; n < T; n++) p[16*n +: 16] = sub[n];
    return p;
  endfunction

  task automatic check_output(input string name, input logic [543:0] act, input logic [543:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Presents start with key for one edge, then scrambles key to prove it was captured at acceptance.
  task automatic apply_stimulus(input logic [127:0] k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    key   = ~k;
  endtask

  task automatic run_expansion(input string name, input logic [127:0] k, input logic [543:0] exp,
                               input bit early, input int inj_c, input logic [127:0] inj_key);
    int done_cnt;
    int done_at;
    done_cnt = 0;
    done_at  = -1;
    apply_stimulus(k);
    check_output({name, " busy after accept"}, 544'(busy), 544'(1'b1));
    check_output({name, " ready after accept"}, 544'(ready), 544'(1'b0));
    for (int c = 1; c <= LAT + 3; c++) begin
      if (c == inj_c) begin
        start = 1'b1;
        key   = inj_key;
      end
      @(posedge clk);
      #1;
      if (c == inj_c) begin
        start = 1'b0;
        key   = ~inj_key;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (early && c == INIT_CYC + 1) begin
        check_output({name, " S0 first MIX"}, 544'(sub[0]), 544'(16'hB7E1));
        check_output({name, " S1 first MIX"}, 544'(sub[1]), 544'(16'h5618));
        check_output({name, " S33 first MIX"}, 544'(sub[33]), 544'(16'h1CF8));
      end
      if (early && c == INIT_CYC + 2) begin
        check_output({name, " S0 after iter0"}, 544'(sub[0]), 544'(16'hBF0D));
      end
      if (c == LAT) begin
        check_output({name, " busy at done"}, 544'(busy), 544'(1'b0));
        check_output({name, " ready at done"}, 544'(ready), 544'(1'b1));
      end
    end
    check_output({name, " done latency"}, 544'(done_at), 544'(LAT));
    check_output({name, " done pulse count"}, 544'(done_cnt), 544'(1));
    check_output({name, " ready held"}, 544'(ready), 544'(1'b1));
    check_output({name, " table"}, pack_sub(), exp);
  endtask

  initial begin
    logic [543:0] exp_a, exp_b, exp_zero;
    bit           saw_ready;
    int           n_done, n_ready, n_pred;

    rst   = 1'b1;
    start = 1'b0;
    key   = '0;

    vecs[0].key = 128'h0;
    vecs[1].key = 128'h0F0E0D0C0B0A09080706050403020100;
    vecs[2].key = 128'hA5A5_5A5A_0123_4567_89AB_CDEF_F00D_BEEF;
    vecs[3].key = {128{1'b1}};
    for (int v = 0; v < 4; v++) model_table(vecs[v].key, vecs[v].exp);
    exp_zero = '0;

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    check_output("reset busy", 544'(busy), 544'(1'b0));
    check_output("reset ready", 544'(ready), 544'(1'b0));
    check_output("reset done", 544'(done), 544'(1'b0));
    check_output("reset table", pack_sub(), exp_zero);
    rst = 1'b0;

    $display("[TB] table-driven expansions");
    for (int v = 0; v < 4; v++) begin
      run_expansion($sformatf("vec%0d", v), vecs[v].key, vecs[v].exp, (v == 0), 0, '0);
    end

    $display("[TB] start during expansion is ignored");
    run_expansion("ignore", vecs[1].key, vecs[1].exp, 1'b0, 50, vecs[2].key);

    $display("[TB] reset during MIX");
    saw_ready = 1'b0;
    apply_stimulus(vecs[2].key);
    for (int c = 1; c <= INIT_CYC + 80; c++) begin
      @(posedge clk);
      #1;
      if (ready) saw_ready = 1'b1;
    end
    check_output("abort ready low in flight", 544'(saw_ready), 544'(1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("abort busy", 544'(busy), 544'(1'b0));
    check_output("abort ready", 544'(ready), 544'(1'b0));
    check_output("abort table cleared", pack_sub(), exp_zero);
    run_expansion("after abort", vecs[3].key, vecs[3].exp, 1'b0, 0, '0);

    $display("[TB] start held high");
    model_table(vecs[1].key, exp_a);
    n_done  = 0;
    n_ready = 0;
    n_pred  = 0;
    @(negedge clk);
    key   = vecs[1].key;
    start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (ready) n_ready++;
      if (c % (LAT + 1) == LAT) begin
        n_pred++;
        check_output($sformatf("held done at %0d", c), 544'(done), 544'(1'b1));
        check_output($sformatf("held table at %0d", c), pack_sub(), exp_a);
      end else if (done) begin
        check_output($sformatf("held stray done at %0d", c), 544'(done), 544'(1'b0));
      end
      if (done) n_done++;
    end
    start = 1'b0;
    check_output("held done count", 544'(n_done), 544'(n_pred));
    check_output("held ready cycles", 544'(n_ready), 544'(n_pred));

    repeat (LAT + 2) @(posedge clk);
    #1;
    model_table(vecs[1].key, exp_b);
    check_output("held final table", pack_sub(), exp_b);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
